// File: rtl/uart_rx_framed.sv
// uart_rx_framed
//   Oversampling UART receiver with configurable data width, parity and stop
//   bits, 2-of-3 majority bit decisions and a valid/ready output holding
//   register with overrun detection.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   RxD        in   asynchronous serial line, idles high
//   rx_data    out  received word, first bit received at the LSB
//   rx_valid   out  rx_data (and the error flags) are held valid
//   rx_ready   in   consumer accepts the held word
//   parity_err out  parity mismatch on the held word
//   frame_err  out  a stop bit of the held word was sampled low
//   overrun    out  an unaccepted word was overwritten (sticky until accept)
//   busy       out  receiver is inside a frame
//
// state | meaning
// IDLE  | waiting for a high-to-low edge on an armed (seen-high) line
// START | checking the start bit at mid-bit; a high sample is a glitch
// DATA  | shifting in DATA_BITS majority-decided bits, LSB first
// PAR   | deciding the parity bit and computing the parity error
// STOP  | deciding STOP_BITS stop bits; the last decision loads the output
module uart_rx_framed #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_DEN = BAUD * OVERSAMPLE;
  localparam int DIV_RAW  = (CLK_FREQ + TICK_DEN / 2) / TICK_DEN;
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(DIV - 1);
  // bit_tmr counts down from OVERSAMPLE-1, so tick index k within a bit
  // corresponds to bit_tmr == OVERSAMPLE-1-k.
  localparam logic [OS_W-1:0]  OS_LOAD   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  TC_S0     = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  TC_S1     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  TC_S2     = OS_W'(OVERSAMPLE / 2 - 2);
  localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LOAD = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state;
  logic                   rxd_meta, rxd_sync;
  logic [1:0]             sync_vld;
  logic                   armed;
  logic [DIV_W-1:0]       div_cnt;
  logic [OS_W-1:0]        bit_tmr;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   stop_cnt;
  logic [1:0]             smp;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr_acc, ferr_acc;

  logic tick, start_det, at_s0, at_s1, at_dec, at_end;
  logic bit_maj, ferr_now, load;

  assign tick      = (div_cnt == '0);
  assign start_det = (state == IDLE) && armed && !rxd_sync;
  assign at_s0     = tick && (bit_tmr == TC_S0);
  assign at_s1     = tick && (bit_tmr == TC_S1);
  assign at_dec    = tick && (bit_tmr == TC_S2);
  assign at_end    = tick && (bit_tmr == '0);
  // Third sample is taken live on the deciding tick.
  assign bit_maj   = (smp[0] & smp[1]) | (smp[0] & rxd_sync) | (smp[1] & rxd_sync);
  assign ferr_now  = ferr_acc | ~bit_maj;
  assign load      = (state == STOP) && at_dec && (stop_cnt == 1'b0);

  // sync_vld keeps the reset value of the synchroniser from being taken as
  // a real high level on the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      sync_vld <= 2'b00;
    end else begin
      rxd_meta <= RxD;
      rxd_sync <= rxd_meta;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (start_det || tick) begin
      div_cnt <= DIV_LOAD;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      armed      <= 1'b0;
      bit_tmr    <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      smp        <= '0;
      shreg      <= '0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      busy       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if ((state != IDLE) && tick) begin
        bit_tmr <= (bit_tmr == '0) ? OS_LOAD : bit_tmr - 1'b1;
        if (at_s0) smp[0] <= rxd_sync;
        if (at_s1) smp[1] <= rxd_sync;
      end

      // Bit decisions advance the state mid-bit; bit_tmr keeps the bit
      // boundaries, so the next decision lands in the following bit.
      case (state)
        IDLE: begin
          if (start_det) begin
            state    <= START;
            armed    <= 1'b0;
            busy     <= 1'b1;
            bit_tmr  <= OS_LOAD;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
          end else if (rxd_sync && sync_vld[1]) begin
            armed <= 1'b1;
          end
        end
        START: begin
          if (at_s1 && rxd_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (at_end) begin
            state   <= DATA;
            bit_cnt <= BIT_LOAD;
          end
        end
        DATA: begin
          if (at_dec) begin
            shreg <= {bit_maj, shreg[DATA_BITS-1:1]};
            if (bit_cnt == '0) begin
              stop_cnt <= STOP_LOAD;
              state    <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        PAR: begin
          if (at_dec) begin
            perr_acc <= (PARITY == 1) ? ~(^shreg ^ bit_maj) : (^shreg ^ bit_maj);
            state    <= STOP;
          end
        end
        STOP: begin
          if (at_dec) begin
            if (stop_cnt == 1'b0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= 1'b0;
              ferr_acc <= ferr_now;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A load coinciding with an acceptance replaces the word cleanly.
      if (load) begin
        rx_data    <= shreg;
        parity_err <= perr_acc;
        frame_err  <= ferr_now;
        rx_valid   <= 1'b1;
        if (rx_valid) overrun <= !rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, ticks per bit period; legal values are even and at least 4.
REQ-004 SHALL have parameter DATA_BITS, default 8, frame data width; legal range 5-9.
REQ-005 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-006 SHALL have parameter STOP_BITS, default 1, number of stop bits checked; legal values 1-2.
REQ-007 SHALL have port clk, input, 1, single clock for all logic.
REQ-008 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port RxD, input, 1, asynchronous serial line; idles high.
REQ-010 SHALL have port rx_data, output, DATA_BITS, received word with the first bit received at the LSB.
REQ-011 SHALL have port rx_valid, output, 1, rx_data is held valid.
REQ-012 SHALL have port rx_ready, input, 1, consumer accepts the word.
REQ-013 SHALL have port parity_err, output, 1, parity mismatch on the word held in rx_data.
REQ-014 SHALL have port frame_err, output, 1, a stop bit was sampled low on the word held.
REQ-015 SHALL have port overrun, output, 1, an unaccepted word was overwritten.
REQ-016 SHALL have port busy, output, 1, receiver state is not IDLE.

Function
REQ-017 SHALL pass RxD through a two-flop synchroniser, reset to 1, before any use.
REQ-018 SHALL generate a tick enable every round(CLK_FREQ/(BAUD*OVERSAMPLE)) clocks, with a minimum of 1; the tick counter SHALL restart at each detected start edge.
REQ-019 SHALL implement states IDLE, START, DATA, PAR, STOP.
REQ-020 IDLE: a synchronised high-to-low transition SHALL go to START and clear the tick-in-bit counter.
REQ-021 START: at tick OVERSAMPLE/2 the line SHALL be sampled; if low, go to DATA; if high, the event is a glitch and the state SHALL return to IDLE with no output change.
REQ-022 Each bit SHALL be decided by a 2-of-3 majority of samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-023 DATA: SHALL shift in DATA_BITS bits, LSB first, into an internal shift register.
REQ-024 After DATA, the state SHALL go to PAR if PARITY is nonzero and to STOP otherwise.
REQ-025 PAR: SHALL compute a parity error as follows: for odd parity, the XOR of the data bits and the parity bit equals 0; for even parity, it equals 1.
REQ-026 STOP: SHALL sample STOP_BITS stop bits; any low stop bit SHALL set the frame error.
REQ-027 STOP: after the final stop-bit decision, the state SHALL return to IDLE without waiting for the full bit period, allowing back-to-back frames.
REQ-028 At the final stop-bit decision, the next clock SHALL load rx_data, parity_err and frame_err, and SHALL assert rx_valid.
REQ-029 Data SHALL be delivered even when errors are flagged.
REQ-030 rx_valid SHALL stay high and the rx_data and error outputs SHALL stay stable until a clock with rx_valid and rx_ready both high.
REQ-031 On a clock with rx_valid and rx_ready both high, rx_valid SHALL deassert on the next clock unless a new word loads on that same clock.
REQ-032 If a new load and an acceptance coincide, the new word SHALL load, rx_valid SHALL remain 1, and overrun SHALL NOT set.
REQ-033 If a new word loads while rx_valid=1 and rx_ready=0, the new word SHALL overwrite the held word and overrun SHALL set.
REQ-034 overrun SHALL be sticky until the next acceptance, and SHALL clear on that acceptance.
REQ-035 A line held low (break condition) SHALL produce one word with frame_err=1, then SHALL wait in IDLE for a high level before re-arming edge detection.

Reset
REQ-036 While rst=0, the block SHALL force state IDLE, all counters to 0, rx_data to 0, rx_valid, parity_err, frame_err, overrun and busy to 0, and the synchroniser to 1, all asynchronously.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame, with no rx_valid pulse after release.
REQ-038 After reset release, the line SHALL be seen high before the first start edge is accepted.

Verification
REQ-039 Bench parameters: CLK_FREQ=16_000_000, BAUD=1_000_000, OVERSAMPLE=16 (one tick per clock, 16 clocks per bit).
REQ-040 Scenario 1: 8N1 frame 0xA5 with rx_ready=1 -> rx_data=0xA5 and rx_valid high for 1 clock, with no error flags.
REQ-041 Scenario 2: PARITY=2, 0x37 sent with parity bit 0 -> rx_data=0x37 and parity_err=1; with parity bit 1 -> parity_err=0.
REQ-042 Scenario 3: 8-clock low glitch on idle line -> no rx_valid and busy returns to 0; a following 0x5A frame is received correctly.
REQ-043 Scenario 4: frames 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data=0x22 and overrun=1; asserting rx_ready for 1 clock then gives rx_valid=0 and overrun=0.
REQ-044 Scenario 5: frame 0xFF with stop bit low -> frame_err=1; a 20-bit break then produces exactly one word, 0x00 with frame_err=1.
REQ-045 Scenario 6: rst pulsed low during data bit 4 of frame 0xC3 -> all outputs 0 immediately, no rx_valid afterwards; the next 0x3C frame is received correctly.
